branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the update-queue entry count (power of two, minimum 2).
REQ-002 SHALL have port bru_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port bru_reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port bru_ex_valid  input  1  resolved branch presented by execute this cycle.
REQ-005 SHALL have port bru_ex_pc  input  32  PC of the resolved branch.
REQ-006 SHALL have port bru_ex_taken  input  1  actual branch outcome.
REQ-007 SHALL have port bru_ex_target  input  32  actual taken target.
REQ-008 SHALL have port bru_ex_pred_taken  input  1  prediction carried from fetch (BTB valid prediction).
REQ-009 SHALL have port bru_ex_pred_target  input  32  predicted target carried from fetch.
REQ-010 SHALL have port bru_ex_ready  output  1  queue can accept a branch.
REQ-011 SHALL have port bru_btb_ready  input  1  BTB write port free this cycle.
REQ-012 SHALL have port bru_btb_write  output  1  drives BTB write enable.
REQ-013 SHALL have port bru_btb_branch_taken  output  1  drives BTB taken bit for predictor update.
REQ-014 SHALL have port bru_btb_new_pc  output  32  drives BTB index/tag PC.
REQ-015 SHALL have port bru_btb_data  output  32  drives BTB target data.
REQ-016 SHALL have port bru_flush  output  1  one-cycle misprediction flush pulse.
REQ-017 SHALL have port bru_redirect_pc  output  32  correct fetch PC, valid while bru_flush high.
REQ-018 SHALL have port bru_mispredict_count  output  16  saturating misprediction counter.

Function
REQ-019 Accept (push) SHALL occur when bru_ex_valid and bru_ex_ready are both high.
REQ-020 bru_ex_ready SHALL equal NOT full; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-021 Mispredict SHALL be (pred_taken != taken) OR (taken AND pred_taken AND pred_target != target), evaluated on accepted branches only.
REQ-022 On accepted mispredict, bru_flush SHALL be high for exactly the next cycle, with bru_redirect_pc = target if taken, else pc + 4 (32-bit wrap).
REQ-023 bru_flush SHALL be 0 in the cycle after a correct prediction or no accept.
REQ-024 Each accepted branch SHALL be pushed as {pc, taken, target} regardless of mispredict.
REQ-025 bru_btb_write SHALL equal NOT empty; BTB outputs SHALL show the head entry combinationally from queue storage.
REQ-026 Pop SHALL occur when bru_btb_write and bru_btb_ready are both high; entries leave strictly in push order.
REQ-027 A push into an empty queue SHALL appear on BTB outputs the following cycle (one-cycle latency, no bypass).
REQ-028 Simultaneous push and pop SHALL keep occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-029 bru_mispredict_count SHALL increment by 1 per mispredict and hold at 0xFFFF.
REQ-030 Entries already queued SHALL NOT be discarded by bru_flush (they are older than the flushed branch).

Reset
REQ-031 bru_reset low SHALL immediately clear pointers/occupancy (empty), bru_flush, bru_redirect_pc and bru_mispredict_count to 0, giving bru_btb_write=0 and bru_ex_ready=1.
REQ-032 Reset mid-operation SHALL drop all queued entries and any pending flush; no BTB write after release until a new push.
REQ-033 Queue data storage SHALL NOT require reset.

Structure
REQ-034 A shared package SHALL hold the bru_entry_t struct {pc, taken, target}, the PC_INCR constant (4) and the counter width (16).
REQ-035 One sub-module, bru_fifo (parameterised sync FIFO with full/empty), SHALL hold the queue.

Verification
REQ-036 Taken branch pc=0x04 target=0xDEADBEEF, pred_taken=1, pred_target=0xDEADBEEF, btb_ready=1 -> no flush; next cycle btb_write=1, new_pc=0x04, data=0xDEADBEEF, taken=1.
REQ-037 pc=0x00, taken=0, pred_taken=1 -> flush pulse 1 cycle, redirect_pc=0x04, count=1.
REQ-038 btb_ready=0, 4 back-to-back accepts -> ex_ready=0 after the 4th; raise btb_ready -> 4 writes in push order, ex_ready=1 after the first pop.
REQ-039 Taken pc=0x10, pred_target=0x20 vs target=0x30 -> flush, redirect_pc=0x30.
REQ-040 Mispredict counter preloaded near 0xFFFE via 3 mispredicts -> saturates at 0xFFFF.
REQ-041 Reset asserted with 3 entries queued and flush pending -> btb_write=0, flush=0, count=0 immediately.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit.
// The entry struct is the unit of storage in the BTB update queue.
package branch_resolve_unit_pkg;

    localparam logic [31:0] PC_INCR = 32'd4;
    localparam int          CNT_W   = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bru_entry_t;

    // A taken branch whose target differs from the prediction also counts as wrong
    function automatic logic is_mispredict(input logic        taken,
                                           input logic        pred_taken,
                                           input logic [31:0] target,
                                           input logic [31:0] pred_target);
        return (pred_taken != taken) || (taken && pred_taken && (pred_target != target));
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Execute-side and BTB-side signal bundle of the branch resolve unit.
// master = execute stage / BTB environment, slave = the resolve unit.
interface branch_resolve_unit_if;
    import branch_resolve_unit_pkg::*;

    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic             ex_ready;
    logic             btb_ready;
    logic             btb_write;
    logic             btb_branch_taken;
    logic [31:0]      btb_new_pc;
    logic [31:0]      btb_data;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target, btb_ready,
        input  ex_ready, btb_write, btb_branch_taken, btb_new_pc, btb_data,
               flush, redirect_pc, mispredict_count
    );

    modport slave (
        input  ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target, btb_ready,
        output ex_ready, btb_write, btb_branch_taken, btb_new_pc, btb_data,
               flush, redirect_pc, mispredict_count
    );

endinterface

// File: rtl/branch_resolve_unit_fifo.sv
// Synchronous FIFO, DEPTH a power of two; head data read combinationally from storage.
// Push ignored when full, pop ignored when empty; storage itself is not reset.
module bru_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches from execute: one-cycle flush/redirect on mispredict, queues BTB updates.
// Latency: flush 1 cycle after accept, BTB write earliest 1 cycle after accept; ex_ready = !full.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             bru_clk,
    input  logic             bru_reset,
    input  logic             bru_ex_valid,
    input  logic [31:0]      bru_ex_pc,
    input  logic             bru_ex_taken,
    input  logic [31:0]      bru_ex_target,
    input  logic             bru_ex_pred_taken,
    input  logic [31:0]      bru_ex_pred_target,
    output logic             bru_ex_ready,
    input  logic             bru_btb_ready,
    output logic             bru_btb_write,
    output logic             bru_btb_branch_taken,
    output logic [31:0]      bru_btb_new_pc,
    output logic [31:0]      bru_btb_data,
    output logic             bru_flush,
    output logic [31:0]      bru_redirect_pc,
    output logic [CNT_W-1:0] bru_mispredict_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_pop;
    logic       w_mispredict;
    bru_entry_t w_push_dat;
    bru_entry_t w_head;

    logic             r_flush;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_mispredict_count;

    assign bru_ex_ready  = !w_full;
    assign bru_btb_write = !w_empty;
    assign w_accept      = bru_ex_valid && bru_ex_ready;
    assign w_pop         = bru_btb_write && bru_btb_ready;
    assign w_mispredict  = w_accept && is_mispredict(bru_ex_taken, bru_ex_pred_taken,
                                                     bru_ex_target, bru_ex_pred_target);

    assign w_push_dat = '{pc: bru_ex_pc, taken: bru_ex_taken, target: bru_ex_target};

    bru_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(bru_entry_t))
    ) u_fifo (
        .i_clk      (bru_clk),
        .i_rst_n    (bru_reset),
        .i_push     (w_accept),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign bru_btb_new_pc       = w_head.pc;
    assign bru_btb_branch_taken = w_head.taken;
    assign bru_btb_data         = w_head.target;

    // Redirect only meaningful while flush is high, so it simply holds otherwise
    always_ff @(posedge bru_clk or negedge bru_reset) begin
        if (!bru_reset) begin
            r_flush            <= 1'b0;
            r_redirect_pc      <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_flush <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= bru_ex_taken ? bru_ex_target : (bru_ex_pc + PC_INCR);
                if (r_mispredict_count != CNT_MAX) begin
                    r_mispredict_count <= r_mispredict_count + CNT_INC;
                end
            end
        end
    end

    assign bru_flush            = r_flush;
    assign bru_redirect_pc      = r_redirect_pc;
    assign bru_mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed expectations checked with immediate assertions.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    logic bru_clk;
    logic bru_reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    branch_resolve_unit_if bif ();

    branch_resolve_unit #(.DEPTH(4)) dut (
        .bru_clk              (bru_clk),
        .bru_reset            (bru_reset),
        .bru_ex_valid         (bif.ex_valid),
        .bru_ex_pc            (bif.ex_pc),
        .bru_ex_taken         (bif.ex_taken),
        .bru_ex_target        (bif.ex_target),
        .bru_ex_pred_taken    (bif.ex_pred_taken),
        .bru_ex_pred_target   (bif.ex_pred_target),
        .bru_ex_ready         (bif.ex_ready),
        .bru_btb_ready        (bif.btb_ready),
        .bru_btb_write        (bif.btb_write),
        .bru_btb_branch_taken (bif.btb_branch_taken),
        .bru_btb_new_pc       (bif.btb_new_pc),
        .bru_btb_data         (bif.btb_data),
        .bru_flush            (bif.flush),
        .bru_redirect_pc      (bif.redirect_pc),
        .bru_mispredict_count (bif.mispredict_count)
    );

    initial bru_clk = 1'b0;
    always #5 bru_clk = ~bru_clk;

    task automatic tick();
        @(posedge bru_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bif.ex_valid       = v;
        bif.ex_pc          = pc;
        bif.ex_taken       = tk;
        bif.ex_target      = tgt;
        bif.ex_pred_taken  = ptk;
        bif.ex_pred_target = ptgt;
    endtask

    initial begin
        bru_reset     = 1'b0;
        bif.btb_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("rst_btb_write", 32'(bif.btb_write), 32'd0);
        chk("rst_ex_ready",  32'(bif.ex_ready),  32'd1);
        chk("rst_flush",     32'(bif.flush),     32'd0);
        chk("rst_redirect",  bif.redirect_pc,    32'd0);
        chk("rst_count",     32'(bif.mispredict_count), 32'd0);
        tick();
        tick();
        bru_reset = 1'b1;

        // Correct taken prediction: no flush, BTB update visible one cycle later
        bif.btb_ready = 1'b1;
        drive(1'b1, 32'h4, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("a_flush",     32'(bif.flush),            32'd0);
        chk("a_btb_write", 32'(bif.btb_write),        32'd1);
        chk("a_new_pc",    bif.btb_new_pc,            32'h4);
        chk("a_data",      bif.btb_data,              32'hDEADBEEF);
        chk("a_taken",     32'(bif.btb_branch_taken), 32'd1);
        chk("a_count",     32'(bif.mispredict_count), 32'd0);
        tick();
        chk("a_drained",   32'(bif.btb_write),        32'd0);

        // Predicted taken, actually not taken: redirect to pc+4
        drive(1'b1, 32'h0, 1'b0, 32'h100, 1'b1, 32'h200);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("b_flush",     32'(bif.flush),            32'd1);
        chk("b_redirect",  bif.redirect_pc,           32'h4);
        chk("b_count",     32'(bif.mispredict_count), 32'd1);
        chk("b_btb_write", 32'(bif.btb_write),        32'd1);
        chk("b_new_pc",    bif.btb_new_pc,            32'h0);
        chk("b_taken",     32'(bif.btb_branch_taken), 32'd0);
        chk("b_data",      bif.btb_data,              32'h100);
        tick();
        chk("b_flush_end", 32'(bif.flush),            32'd0);
        chk("b_drained",   32'(bif.btb_write),        32'd0);

        // Taken with wrong predicted target
        drive(1'b1, 32'h10, 1'b1, 32'h30, 1'b1, 32'h20);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("c_flush",     32'(bif.flush),            32'd1);
        chk("c_redirect",  bif.redirect_pc,           32'h30);
        chk("c_count",     32'(bif.mispredict_count), 32'd2);
        tick();
        chk("c_flush_end", 32'(bif.flush),            32'd0);

        // Not-taken fall-through at top of address space wraps to 0
        drive(1'b1, 32'hFFFFFFFC, 1'b0, 32'h40, 1'b1, 32'h40);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("w_flush",     32'(bif.flush),            32'd1);
        chk("w_redirect",  bif.redirect_pc,           32'h0);
        chk("w_count",     32'(bif.mispredict_count), 32'd3);
        tick();

        // Fill the queue with BTB blocked, then drain in order
        bif.btb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i) * 32'd4, i[0], 32'h1000 + 32'(i), i[0], 32'h1000 + 32'(i));
            tick();
            chk($sformatf("d_ready_%0d", i), 32'(bif.ex_ready), (i < 3) ? 32'd1 : 32'd0);
            chk($sformatf("d_flush_%0d", i), 32'(bif.flush), 32'd0);
        end
        drive(1'b1, 32'h500, 1'b1, 32'h5000, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("d_blocked_flush", 32'(bif.flush),            32'd0);
        chk("d_blocked_count", 32'(bif.mispredict_count), 32'd3);
        chk("d_still_full",    32'(bif.ex_ready),         32'd0);
        bif.btb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("d_write_%0d", i), 32'(bif.btb_write),        32'd1);
            chk($sformatf("d_pc_%0d", i),    bif.btb_new_pc,            32'h100 + 32'(i) * 32'd4);
            chk($sformatf("d_data_%0d", i),  bif.btb_data,              32'h1000 + 32'(i));
            chk($sformatf("d_tk_%0d", i),    32'(bif.btb_branch_taken), 32'(i[0]));
            tick();
            if (i == 0) chk("d_ready_after_pop", 32'(bif.ex_ready), 32'd1);
        end
        chk("d_empty", 32'(bif.btb_write), 32'd0);

        // Back-to-back mispredicts with concurrent push/pop, up to counter saturation
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        for (int k = 0; k < 65530; k++) tick();
        chk("e_count_fffd", 32'(bif.mispredict_count), 32'hFFFD);
        chk("e_ready",      32'(bif.ex_ready),         32'd1);
        chk("e_write",      32'(bif.btb_write),        32'd1);
        tick();
        chk("e_count_fffe", 32'(bif.mispredict_count), 32'hFFFE);
        tick();
        chk("e_count_ffff", 32'(bif.mispredict_count), 32'hFFFF);
        tick();
        chk("e_count_hold", 32'(bif.mispredict_count), 32'hFFFF);
        chk("e_flush",      32'(bif.flush),            32'd1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        chk("e_drained",    32'(bif.btb_write),        32'd0);

        // Reset with three queued entries and a flush pending
        bif.btb_ready = 1'b0;
        drive(1'b1, 32'h200, 1'b1, 32'h2000, 1'b1, 32'h2000);
        tick();
        drive(1'b1, 32'h204, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h208, 1'b1, 32'h3000, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("f_pre_flush",    32'(bif.flush),     32'd1);
        chk("f_pre_redirect", bif.redirect_pc,    32'h3000);
        chk("f_pre_write",    32'(bif.btb_write), 32'd1);
        #1;
        bru_reset = 1'b0;
        #1;
        chk("f_rst_write",    32'(bif.btb_write),        32'd0);
        chk("f_rst_flush",    32'(bif.flush),            32'd0);
        chk("f_rst_count",    32'(bif.mispredict_count), 32'd0);
        chk("f_rst_ready",    32'(bif.ex_ready),         32'd1);
        chk("f_rst_redirect", bif.redirect_pc,           32'd0);
        tick();
        bru_reset     = 1'b1;
        bif.btb_ready = 1'b1;
        tick();
        chk("f_no_write", 32'(bif.btb_write), 32'd0);
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("f_new_write", 32'(bif.btb_write),        32'd1);
        chk("f_new_pc",    bif.btb_new_pc,            32'h300);
        chk("f_new_flush", 32'(bif.flush),            32'd0);
        chk("f_new_count", 32'(bif.mispredict_count), 32'd0);
        tick();
        chk("f_final_empty", 32'(bif.btb_write), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
